// File: rtl/disco_dma_if.sv
// Command, disk and RAM signal bundle for the disk<->RAM block-transfer controller.
// The slave modport is the controller's view; master is the system side (CPU, disk, RAM).
interface disco_dma_if #(
  parameter int DATA_WIDTH      = 16,
  parameter int DISK_ADDR_WIDTH = 15,
  parameter int MEM_ADDR_WIDTH  = 10,
  parameter int LEN_WIDTH       = 16
) ();
  logic                       start;
  logic                       dir;
  logic [DISK_ADDR_WIDTH-1:0] disk_base;
  logic [MEM_ADDR_WIDTH-1:0]  mem_base;
  logic [LEN_WIDTH-1:0]       len;
  logic                       busy;
  logic                       done;
  logic [DISK_ADDR_WIDTH-1:0] disk_addr;
  logic [DATA_WIDTH-1:0]      disk_data;
  logic                       disk_tr;
  logic [DATA_WIDTH-1:0]      disk_q;
  logic [MEM_ADDR_WIDTH-1:0]  mem_addr;
  logic [DATA_WIDTH-1:0]      mem_data;
  logic                       mem_we;
  logic [DATA_WIDTH-1:0]      mem_q;

  modport slave (
    input  start, dir, disk_base, mem_base, len, disk_q, mem_q,
    output busy, done, disk_addr, disk_data, disk_tr, mem_addr, mem_data, mem_we
  );

  modport master (
    output start, dir, disk_base, mem_base, len, disk_q, mem_q,
    input  busy, done, disk_addr, disk_data, disk_tr, mem_addr, mem_data, mem_we
  );
endinterface

// File: rtl/disco_dma_ctrl.sv
// Word-by-word block copy between secondary disk and main RAM: LOAD (disk->RAM, 1 word/cycle)
// or STORE (RAM->disk, 2 cycles/word because RAM read data arrives one cycle after the address).
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; latches command
// LOAD  | mem_we=1, RAM word idx <= disk word idx (async disk read)
// ST_RD | RAM address presented for word idx, no strobes
// ST_WR | disk_tr=1, disk word idx <= RAM read data
// DONE  | one-cycle done pulse, then back to IDLE
module disco_dma_ctrl #(
  parameter int DATA_WIDTH      = 16,
  parameter int DISK_ADDR_WIDTH = 15,
  parameter int MEM_ADDR_WIDTH  = 10,
  parameter int LEN_WIDTH       = 16
) (
  input  logic         clk,
  input  logic         rst,
  disco_dma_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ST_RD = 3'd2,
    S_ST_WR = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                     state_q, state_d;
  logic [LEN_WIDTH-1:0]       idx_q, idx_d;
  logic [LEN_WIDTH-1:0]       len_q, len_d;
  logic [DISK_ADDR_WIDTH-1:0] disk_base_q, disk_base_d;
  logic [MEM_ADDR_WIDTH-1:0]  mem_base_q, mem_base_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic                       mem_we_q, mem_we_d;
  logic                       disk_tr_q, disk_tr_d;
  logic                       last_word;

  assign last_word = (idx_q == (len_q - LEN_WIDTH'(1)));

  // Strobes are computed one state ahead so they come straight out of flops.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    len_d       = len_q;
    disk_base_d = disk_base_q;
    mem_base_d  = mem_base_q;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    mem_we_d    = 1'b0;
    disk_tr_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          len_d       = bus.len;
          disk_base_d = bus.disk_base;
          mem_base_d  = bus.mem_base;
          idx_d       = '0;
          if (bus.len == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else if (!bus.dir) begin
            state_d  = S_LOAD;
            busy_d   = 1'b1;
            mem_we_d = 1'b1;
          end else begin
            state_d = S_ST_RD;
            busy_d  = 1'b1;
          end
        end
      end
      S_LOAD: begin
        idx_d = idx_q + LEN_WIDTH'(1);
        if (last_word) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          busy_d   = 1'b1;
          mem_we_d = 1'b1;
        end
      end
      S_ST_RD: begin
        state_d   = S_ST_WR;
        busy_d    = 1'b1;
        disk_tr_d = 1'b1;
      end
      S_ST_WR: begin
        idx_d = idx_q + LEN_WIDTH'(1);
        if (last_word) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = S_ST_RD;
          busy_d  = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      len_q       <= '0;
      disk_base_q <= '0;
      mem_base_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mem_we_q    <= 1'b0;
      disk_tr_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      len_q       <= len_d;
      disk_base_q <= disk_base_d;
      mem_base_q  <= mem_base_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      mem_we_q    <= mem_we_d;
      disk_tr_q   <= disk_tr_d;
    end
  end

  // busy is high exactly in LOAD/ST_RD/ST_WR, so it also gates the address outputs.
  logic [DATA_WIDTH-1:0] mem_data_c, disk_data_c;
  assign mem_data_c  = mem_we_q  ? bus.disk_q : '0;
  assign disk_data_c = disk_tr_q ? bus.mem_q  : '0;

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.disk_tr   = disk_tr_q;
  assign bus.disk_addr = busy_q ? (disk_base_q + DISK_ADDR_WIDTH'(idx_q)) : '0;
  assign bus.mem_addr  = busy_q ? (mem_base_q + MEM_ADDR_WIDTH'(idx_q)) : '0;
  assign bus.mem_data  = mem_data_c;
  assign bus.disk_data = disk_data_c;

endmodule

// File: tb/tb_disco_dma_ctrl.sv
// Bench for disco_dma_ctrl: disk/RAM models, directed command table, reset corner cases
// and randomized commands checked against a word-copy reference model.
module tb_disco_dma_ctrl;
  localparam int DISK_WORDS = 32768;
  localparam int MEM_WORDS  = 1024;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  disco_dma_if bus ();
  disco_dma_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  logic [15:0] disk_mem [0:DISK_WORDS-1];
  logic [15:0] ram      [0:MEM_WORDS-1];
  logic [15:0] mem_q_r;
  logic        bd_en = 1'b0, bd_disk = 1'b0;
  logic [14:0] bd_addr = '0;
  logic [15:0] bd_data = '0;

  assign bus.disk_q = disk_mem[bus.disk_addr];
  assign bus.mem_q  = mem_q_r;

  always @(posedge clk) begin
    if (bus.disk_tr) disk_mem[bus.disk_addr] <= bus.disk_data;
    if (bus.mem_we)  ram[bus.mem_addr] <= bus.mem_data;
    if (bd_en && bd_disk)  disk_mem[bd_addr] <= bd_data;
    if (bd_en && !bd_disk) ram[bd_addr[9:0]] <= bd_data;
    mem_q_r <= ram[bus.mem_addr];
  end

  int n_cmp = 0, n_bad = 0, n_done = 0, viol = 0;
  int wq_disk[$], wq_mem[$];

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.done) n_done++;
      if (bus.mem_we && bus.disk_tr) viol++;
      if ((bus.mem_we || bus.disk_tr) && !bus.busy) viol++;
      if (bus.busy && bus.done) viol++;
      if (bus.mem_we || bus.disk_tr) begin
        wq_disk.push_back(int'(bus.disk_addr));
        wq_mem.push_back(int'(bus.mem_addr));
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic bd_write(input logic sel_disk, input int addr, input logic [15:0] d);
    @(negedge clk);
    bd_en = 1'b1; bd_disk = sel_disk; bd_addr = 15'(addr); bd_data = d;
    @(negedge clk);
    bd_en = 1'b0;
  endtask

  task automatic preload_src(input logic d, input int db, input int mb, input int n);
    for (int i = 0; i < n; i++) begin
      if (d) bd_write(1'b0, (mb + i) % MEM_WORDS, 16'($urandom));
      else   bd_write(1'b1, (db + i) % DISK_WORDS, 16'($urandom));
    end
  endtask

  // Reference model: destination word (base+i) mod size receives source word (base+i) mod size.
  task automatic run_cmd(input string tag, input logic d, input int db, input int mb, input int n,
                         input bit noise, input int exp_lat, input int exp_busy);
    logic [15:0] src[$];
    logic [15:0] pre_w, post_w, got;
    int w0, d0, lat, busyc, dst_base, dst_size, bad_addr;
    dst_base = d ? db : mb;
    dst_size = d ? DISK_WORDS : MEM_WORDS;
    for (int i = 0; i < n; i++)
      src.push_back(d ? ram[(mb + i) % MEM_WORDS] : disk_mem[(db + i) % DISK_WORDS]);
    pre_w  = d ? disk_mem[(db + DISK_WORDS - 1) % DISK_WORDS] : ram[(mb + MEM_WORDS - 1) % MEM_WORDS];
    post_w = d ? disk_mem[(db + n) % DISK_WORDS] : ram[(mb + n) % MEM_WORDS];
    w0 = wq_disk.size(); d0 = n_done; lat = 0; busyc = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.dir = d; bus.disk_base = 15'(db); bus.mem_base = 10'(mb); bus.len = 16'(n);
    @(posedge clk); #1;
    if (!noise) bus.start = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      if (bus.done) begin lat = c; break; end
      if (bus.busy) busyc++;
      if (noise) begin
        bus.start = 1'b1; bus.dir = 1'($urandom); bus.len = 16'($urandom_range(1, 5));
        bus.disk_base = 15'($urandom); bus.mem_base = 10'($urandom);
      end
      @(posedge clk); #1;
    end
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, " busy_cycles"}, 32'(busyc), 32'(exp_busy));
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk({tag, " done_width"}, {31'b0, bus.done}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk({tag, " idle_after"}, {31'b0, bus.busy}, 32'd0);
    chk({tag, " done_count"}, 32'(n_done - d0), 32'd1);
    chk({tag, " strobe_count"}, 32'(wq_disk.size() - w0), 32'(n));
    bad_addr = 0;
    for (int i = 0; i < n && (w0 + i) < wq_disk.size(); i++) begin
      if (wq_disk[w0 + i] != (db + i) % DISK_WORDS) bad_addr++;
      if (wq_mem[w0 + i] != (mb + i) % MEM_WORDS) bad_addr++;
    end
    chk({tag, " addr_seq"}, 32'(bad_addr), 32'd0);
    for (int i = 0; i < n; i++) begin
      got = d ? disk_mem[(db + i) % DISK_WORDS] : ram[(mb + i) % MEM_WORDS];
      chk($sformatf("%s data[%0d]", tag, i), {16'b0, got}, {16'b0, src[i]});
    end
    if (n + 2 <= dst_size) begin
      got = d ? disk_mem[(db + DISK_WORDS - 1) % DISK_WORDS] : ram[(mb + MEM_WORDS - 1) % MEM_WORDS];
      chk({tag, " below_untouched"}, {16'b0, got}, {16'b0, pre_w});
      got = d ? disk_mem[(db + n) % DISK_WORDS] : ram[(mb + n) % MEM_WORDS];
      chk({tag, " above_untouched"}, {16'b0, got}, {16'b0, post_w});
    end
    if (dst_base < 0) $display("note: negative base %0d", dst_base);
  endtask

  typedef struct {
    string tag;
    logic  dir;
    int    db;
    int    mb;
    int    n;
    bit    noise;
    int    exp_lat;
    int    exp_busy;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int d0, w0, rd, rdb, rmb, rn;
    logic [15:0] w_first;
    bus.start = 1'b0; bus.dir = 1'b0; bus.disk_base = '0; bus.mem_base = '0; bus.len = '0;
    vecs.push_back('{"T1_load",      1'b0, 1,       100,  4, 1'b0, 5, 4});
    vecs.push_back('{"T2_store",     1'b1, 17232,   20,   3, 1'b0, 7, 6});
    vecs.push_back('{"T3_len0_ld",   1'b0, 5,       5,    0, 1'b0, 1, 0});
    vecs.push_back('{"T3_len0_st",   1'b1, 9,       9,    0, 1'b0, 1, 0});
    vecs.push_back('{"T4_disk_wrap", 1'b0, 'h7FFE,  10,   3, 1'b0, 4, 3});
    vecs.push_back('{"T4_mem_wrap",  1'b0, 200,     1023, 2, 1'b0, 3, 2});
    vecs.push_back('{"T4_st_wrap",   1'b1, 'h7FFF,  1022, 3, 1'b0, 7, 6});
    vecs.push_back('{"T6_noise_ld",  1'b0, 300,     400,  5, 1'b1, 6, 5});
    vecs.push_back('{"T6_noise_st",  1'b1, 600,     700,  4, 1'b1, 9, 8});
    vecs.push_back('{"T6_noise_0",   1'b0, 50,      60,   0, 1'b1, 1, 0});

    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", {31'b0, bus.busy}, 32'd0);
    chk("reset done", {31'b0, bus.done}, 32'd0);
    chk("reset strobes", {30'b0, bus.mem_we, bus.disk_tr}, 32'd0);
    chk("reset addrs", {7'b0, bus.disk_addr, bus.mem_addr}, 32'd0);
    chk("reset data", {bus.disk_data, bus.mem_data}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[v]) begin
      preload_src(vecs[v].dir, vecs[v].db, vecs[v].mb, vecs[v].n);
      run_cmd(vecs[v].tag, vecs[v].dir, vecs[v].db, vecs[v].mb, vecs[v].n,
              vecs[v].noise, vecs[v].exp_lat, vecs[v].exp_busy);
    end

    // T5: reset during the second word of an 8-word LOAD
    preload_src(1'b0, 1000, 500, 8);
    w_first = disk_mem[1000];
    d0 = n_done;
    @(negedge clk);
    bus.start = 1'b1; bus.dir = 1'b0; bus.disk_base = 15'd1000; bus.mem_base = 10'd500; bus.len = 16'd8;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("T5 busy_after_rst", {31'b0, bus.busy}, 32'd0);
    chk("T5 mem_we_after_rst", {31'b0, bus.mem_we}, 32'd0);
    chk("T5 done_after_rst", {31'b0, bus.done}, 32'd0);
    repeat (12) @(posedge clk);
    #1;
    chk("T5 no_done", 32'(n_done - d0), 32'd0);
    chk("T5 word0_kept", {16'b0, ram[500]}, {16'b0, w_first});
    preload_src(1'b0, 2000, 800, 6);
    run_cmd("T5_restart", 1'b0, 2000, 800, 6, 1'b0, 7, 6);

    // reset and start on the same edge: command dropped
    d0 = n_done; w0 = wq_disk.size();
    @(negedge clk);
    rst = 1'b1;
    bus.start = 1'b1; bus.dir = 1'b0; bus.disk_base = 15'd3; bus.mem_base = 10'd3; bus.len = 16'd3;
    @(posedge clk); #1;
    rst = 1'b0; bus.start = 1'b0;
    chk("RS busy", {31'b0, bus.busy}, 32'd0);
    repeat (8) @(posedge clk);
    #1;
    chk("RS no_done", 32'(n_done - d0), 32'd0);
    chk("RS no_writes", 32'(wq_disk.size() - w0), 32'd0);

    for (int r = 0; r < 25; r++) begin
      rd  = $urandom_range(0, 1);
      rdb = $urandom_range(0, DISK_WORDS - 1);
      rmb = $urandom_range(0, MEM_WORDS - 1);
      rn  = $urandom_range(0, 12);
      preload_src(1'(rd), rdb, rmb, rn);
      run_cmd($sformatf("R%0d", r), 1'(rd), rdb, rmb, rn, 1'($urandom_range(0, 1)),
              rn == 0 ? 1 : (rd != 0 ? 1 + 2 * rn : 1 + rn),
              rn == 0 ? 0 : (rd != 0 ? 2 * rn : rn));
    end

    chk("protocol violations", 32'(viol), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
